// File: rtl/tinyrv1_mem_pkg.sv
// Shared definitions for the tinyrv1 test memory: operating modes, dmem
// request types and the default access-counter width.
package tinyrv1_mem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } mem_mode_e;

  localparam logic DMEM_READ  = 1'b0;
  localparam logic DMEM_WRITE = 1'b1;

  localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/mem_write_buffer.sv
// One-entry posted write buffer with read forwarding. The held entry drains
// on the next clock edge while a new write can be captured at that same edge.
module mem_write_buffer import tinyrv1_mem_pkg::*; #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrVal_i,
  input  logic [IDX_W-1:0] wrIdx_i,
  input  logic [31:0]      wrData_i,
  input  logic [IDX_W-1:0] rdIdxA_i,
  input  logic [IDX_W-1:0] rdIdxB_i,
  output logic             hitA_o,
  output logic             hitB_o,
  output logic [31:0]      fwdData_o,
  output logic             drainVal_o,
  output logic [IDX_W-1:0] drainIdx_o,
  output logic [31:0]      drainData_o
);

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      data_q, data_d;

  // The old entry always leaves this cycle, so validity simply follows the new write.
  always_comb begin
    valid_d = wrVal_i;
    idx_d   = wrVal_i ? wrIdx_i : idx_q;
    data_d  = wrVal_i ? wrData_i : data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    hitA_o      = valid_q && (idx_q == rdIdxA_i);
    hitB_o      = valid_q && (idx_q == rdIdxB_i);
    fwdData_o   = data_q;
    drainVal_o  = valid_q;
    drainIdx_o  = idx_q;
    drainData_o = data_q;
  end

endmodule

// File: rtl/mem_responder.sv
// Zero-latency instruction/data memory responder with a LOAD/RUN mode FSM,
// sticky access-error capture and saturating access counters.
module mem_responder import tinyrv1_mem_pkg::*; #(
  parameter int NUM_WORDS = 256,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_val,
  input  logic [31:0]      load_addr,
  input  logic [31:0]      load_data,
  input  logic             run_start,
  output logic             running,
  input  logic             imemreq_val,
  input  logic [31:0]      imemreq_addr,
  output logic [31:0]      imemresp_data,
  input  logic             dmemreq_val,
  input  logic             dmemreq_type,
  input  logic [31:0]      dmemreq_addr,
  input  logic [31:0]      dmemreq_wdata,
  output logic [31:0]      dmemresp_rdata,
  output logic             err,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] cnt_ifetch,
  output logic [CNT_W-1:0] cnt_dread,
  output logic [CNT_W-1:0] cnt_dwrite
);

  localparam int IDX_W = $clog2(NUM_WORDS);

  function automatic logic isLegal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && ((addr >> (IDX_W + 2)) == 32'd0);
  endfunction

  logic [31:0] mem [NUM_WORDS];

  mem_mode_e        mode_q, mode_d;
  logic             err_q, err_d;
  logic [31:0]      errAddr_q, errAddr_d;
  logic [CNT_W-1:0] cntIfetch_q, cntDread_q, cntDwrite_q;

  logic             inRun, iAccept, dRead, dWrite, loadWrite;
  logic             loadBad, iBad, dBad;
  logic [IDX_W-1:0] iIdx, dIdx, loadIdx;
  logic             hitI, hitD, drainVal;
  logic [IDX_W-1:0] drainIdx;
  logic [31:0]      fwdData, drainData;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mode_q <= LOAD;
    else      mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_q == LOAD && run_start) mode_d = RUN;
  end

  always_comb begin
    running = (mode_q == RUN);
  end

  always_comb begin
    inRun     = (mode_q == RUN);
    iIdx      = imemreq_addr[IDX_W+1:2];
    dIdx      = dmemreq_addr[IDX_W+1:2];
    loadIdx   = load_addr[IDX_W+1:2];
    iAccept   = inRun && imemreq_val && isLegal(imemreq_addr);
    dRead     = inRun && dmemreq_val && isLegal(dmemreq_addr) && (dmemreq_type == DMEM_READ);
    dWrite    = inRun && dmemreq_val && isLegal(dmemreq_addr) && (dmemreq_type == DMEM_WRITE);
    loadWrite = !inRun && load_val && isLegal(load_addr);
    loadBad   = !inRun && load_val && !isLegal(load_addr);
    iBad      = inRun && imemreq_val && !isLegal(imemreq_addr);
    dBad      = inRun && dmemreq_val && !isLegal(dmemreq_addr);
  end

  mem_write_buffer #(
    .IDX_W(IDX_W)
  ) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .wrVal_i    (dWrite),
    .wrIdx_i    (dIdx),
    .wrData_i   (dmemreq_wdata),
    .rdIdxA_i   (iIdx),
    .rdIdxB_i   (dIdx),
    .hitA_o     (hitI),
    .hitB_o     (hitD),
    .fwdData_o  (fwdData),
    .drainVal_o (drainVal),
    .drainIdx_o (drainIdx),
    .drainData_o(drainData)
  );

  // Buffer drains only happen in RUN and loads only in LOAD, so one write port suffices.
  always_ff @(posedge clk) begin
    if (drainVal)       mem[drainIdx] <= drainData;
    else if (loadWrite) mem[loadIdx]  <= load_data;
  end

  always_comb begin
    imemresp_data  = iAccept ? (hitI ? fwdData : mem[iIdx]) : 32'd0;
    dmemresp_rdata = dRead   ? (hitD ? fwdData : mem[dIdx]) : 32'd0;
  end

  always_comb begin
    err_d     = err_q;
    errAddr_d = errAddr_q;
    if (loadBad || iBad || dBad) begin
      err_d = 1'b1;
      if (!err_q) errAddr_d = loadBad ? load_addr : (iBad ? imemreq_addr : dmemreq_addr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q     <= 1'b0;
      errAddr_q <= '0;
    end else begin
      err_q     <= err_d;
      errAddr_q <= errAddr_d;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cntIfetch_q <= '0;
      cntDread_q  <= '0;
      cntDwrite_q <= '0;
    end else begin
      if (iAccept && cntIfetch_q != '1) cntIfetch_q <= cntIfetch_q + CNT_W'(1);
      if (dRead   && cntDread_q  != '1) cntDread_q  <= cntDread_q  + CNT_W'(1);
      if (dWrite  && cntDwrite_q != '1) cntDwrite_q <= cntDwrite_q + CNT_W'(1);
    end
  end

  assign err        = err_q;
  assign err_addr   = errAddr_q;
  assign cnt_ifetch = cntIfetch_q;
  assign cnt_dread  = cntDread_q;
  assign cnt_dwrite = cntDwrite_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: an architectural memory model checked every cycle
// against a default instance and a 4-bit-counter instance, plus directed checks.
module tb_mem_responder;
  import tinyrv1_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_val;
  logic [31:0] load_addr, load_data;
  logic        run_start;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr, dmemreq_wdata;

  logic        running, err, satRunning, satErr;
  logic [31:0] imemresp_data, dmemresp_rdata, err_addr;
  logic [31:0] satImem, satDmem, satErrAddr;
  logic [15:0] cnt_ifetch, cnt_dread, cnt_dwrite;
  logic [3:0]  satIfetch, satDread, satDwrite;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .rst(rst),
    .load_val(load_val), .load_addr(load_addr), .load_data(load_data),
    .run_start(run_start), .running(running),
    .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
    .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
    .err(err), .err_addr(err_addr),
    .cnt_ifetch(cnt_ifetch), .cnt_dread(cnt_dread), .cnt_dwrite(cnt_dwrite)
  );

  mem_responder #(.NUM_WORDS(256), .CNT_W(4)) dutSat (
    .clk(clk), .rst(rst),
    .load_val(load_val), .load_addr(load_addr), .load_data(load_data),
    .run_start(run_start), .running(satRunning),
    .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(satImem),
    .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
    .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(satDmem),
    .err(satErr), .err_addr(satErrAddr),
    .cnt_ifetch(satIfetch), .cnt_dread(satDread), .cnt_dwrite(satDwrite)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
  endtask

  // Architectural model: reads see the latest accepted write; a RUN write only
  // becomes durable at the following edge, so reset rolls back to the durable copy.
  logic [31:0] visMem [256];
  logic [31:0] durMem [256];
  bit          visKnown [256];
  bit          durKnown [256];
  bit          mRun = 1'b0;
  bit          mErr = 1'b0;
  logic [31:0] mErrAddr = 32'd0;
  int          mCntI = 0, mCntR = 0, mCntW = 0;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'd1024);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a / 4);
  endfunction

  function automatic logic [31:0] satCnt(input int c, input int w);
    int top;
    top = (1 << w) - 1;
    return (c > top) ? 32'(top) : 32'(c);
  endfunction

  task automatic noteErr(input logic [31:0] a);
    if (!mErr) mErrAddr = a;
    mErr = 1'b1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mRun = 1'b0; mErr = 1'b0; mErrAddr = 32'd0;
      mCntI = 0; mCntR = 0; mCntW = 0;
      visMem = durMem;
      visKnown = durKnown;
    end else begin
      durMem = visMem;
      durKnown = visKnown;
      if (!mRun) begin
        if (load_val) begin
          if (legal(load_addr)) begin
            visMem[widx(load_addr)] = load_data;  visKnown[widx(load_addr)] = 1'b1;
            durMem[widx(load_addr)] = load_data;  durKnown[widx(load_addr)] = 1'b1;
          end else noteErr(load_addr);
        end
        if (run_start) mRun = 1'b1;
      end else begin
        if (imemreq_val) begin
          if (legal(imemreq_addr)) mCntI++;
          else noteErr(imemreq_addr);
        end
        if (dmemreq_val) begin
          if (!legal(dmemreq_addr)) noteErr(dmemreq_addr);
          else if (dmemreq_type == DMEM_WRITE) begin
            visMem[widx(dmemreq_addr)] = dmemreq_wdata;
            visKnown[widx(dmemreq_addr)] = 1'b1;
            mCntW++;
          end else mCntR++;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [31:0] expI, expD;
    bit          chkI, chkD;
    expI = 32'd0; chkI = 1'b1;
    expD = 32'd0; chkD = 1'b1;
    if (rst && mRun && imemreq_val && legal(imemreq_addr)) begin
      if (visKnown[widx(imemreq_addr)]) expI = visMem[widx(imemreq_addr)];
      else chkI = 1'b0;
    end
    if (rst && mRun && dmemreq_val && dmemreq_type == DMEM_READ && legal(dmemreq_addr)) begin
      if (visKnown[widx(dmemreq_addr)]) expD = visMem[widx(dmemreq_addr)];
      else chkD = 1'b0;
    end
    if (chkI) begin
      checkOutput("model imemresp_data", imemresp_data, expI);
      checkOutput("model sat imemresp_data", satImem, expI);
    end
    if (chkD) begin
      checkOutput("model dmemresp_rdata", dmemresp_rdata, expD);
      checkOutput("model sat dmemresp_rdata", satDmem, expD);
    end
    checkOutput("model running", 32'(running), 32'(mRun));
    checkOutput("model sat running", 32'(satRunning), 32'(mRun));
    checkOutput("model err", 32'(err), 32'(mErr));
    checkOutput("model sat err", 32'(satErr), 32'(mErr));
    checkOutput("model err_addr", err_addr, mErrAddr);
    checkOutput("model sat err_addr", satErrAddr, mErrAddr);
    checkOutput("model cnt_ifetch", 32'(cnt_ifetch), satCnt(mCntI, 16));
    checkOutput("model cnt_dread", 32'(cnt_dread), satCnt(mCntR, 16));
    checkOutput("model cnt_dwrite", 32'(cnt_dwrite), satCnt(mCntW, 16));
    checkOutput("model sat cnt_ifetch", 32'(satIfetch), satCnt(mCntI, 4));
    checkOutput("model sat cnt_dread", 32'(satDread), satCnt(mCntR, 4));
    checkOutput("model sat cnt_dwrite", 32'(satDwrite), satCnt(mCntW, 4));
  end

  task automatic applyStimulus(input logic lv, input logic [31:0] la, input logic [31:0] ld,
                               input logic rs, input logic iv, input logic [31:0] ia,
                               input logic dv, input logic dt, input logic [31:0] da,
                               input logic [31:0] dw);
    load_val = lv; load_addr = la; load_data = ld; run_start = rs;
    imemreq_val = iv; imemreq_addr = ia;
    dmemreq_val = dv; dmemreq_type = dt; dmemreq_addr = da; dmemreq_wdata = dw;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, DMEM_READ, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset running", 32'(running), 32'd0);
    checkOutput("reset cnt_ifetch", 32'(cnt_ifetch), 32'd0);
    checkOutput("reset err_addr", err_addr, 32'd0);
    rst = 1'b1;
    tick();

    // Program load, fetch while still in LOAD must read zero.
    applyStimulus(1, 32'h0, 32'h00000093, 0, 0, 0, 0, DMEM_READ, 0, 0); tick();
    applyStimulus(1, 32'h108, 32'h00005555, 0, 0, 0, 0, DMEM_READ, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 0, DMEM_READ, 0, 0); #2;
    checkOutput("load-mode fetch", imemresp_data, 32'd0);
    run_start = 1'b1; tick(); idle(); #2;
    checkOutput("running after run_start", 32'(running), 32'd1);

    applyStimulus(0, 0, 0, 0, 1, 32'h0, 0, DMEM_READ, 0, 0); #2;
    checkOutput("fetch 0x0", imemresp_data, 32'h00000093);
    tick(); idle(); #2;
    checkOutput("cnt_ifetch after first fetch", 32'(cnt_ifetch), 32'd1);

    // Loads and run_start are ignored in RUN.
    applyStimulus(1, 32'h0, 32'h00000099, 1, 0, 0, 0, DMEM_READ, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 0, DMEM_READ, 0, 0); #2;
    checkOutput("fetch after RUN load", imemresp_data, 32'h00000093);
    checkOutput("running after 2nd run_start", 32'(running), 32'd1);
    tick();

    // Forwarding from the buffer, then the same data from the array.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, DMEM_WRITE, 32'h100, 32'hDEADBEEF); #2;
    checkOutput("rdata during write", dmemresp_rdata, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, DMEM_READ, 32'h100, 0); #2;
    checkOutput("forwarded read 0x100", dmemresp_rdata, 32'hDEADBEEF);
    tick(); idle(); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, DMEM_READ, 32'h100, 0); #2;
    checkOutput("array read 0x100", dmemresp_rdata, 32'hDEADBEEF);
    tick();

    // Back-to-back writes to one index, then both ports read it together.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, DMEM_WRITE, 32'h104, 32'h11); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, DMEM_WRITE, 32'h104, 32'h22); tick();
    applyStimulus(0, 0, 0, 0, 1, 32'h104, 1, DMEM_READ, 32'h104, 0); #2;
    checkOutput("b2b dmem read 0x104", dmemresp_rdata, 32'h22);
    checkOutput("b2b imem read 0x104", imemresp_data, 32'h22);
    tick(); idle(); #2;
    checkOutput("cnt_dwrite after b2b", 32'(cnt_dwrite), 32'd3);
    checkOutput("cnt_dread after b2b", 32'(cnt_dread), 32'd3);

    // Drain of one entry while capturing a write to a different index.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, DMEM_WRITE, 32'h10C, 32'h33); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, DMEM_WRITE, 32'h110, 32'h44); tick();
    applyStimulus(0, 0, 0, 0, 1, 32'h110, 1, DMEM_READ, 32'h10C, 0); #2;
    checkOutput("drained read 0x10C", dmemresp_rdata, 32'h33);
    checkOutput("forwarded fetch 0x110", imemresp_data, 32'h44);
    tick();

    // Illegal accesses: misaligned, out of range, illegal fetch.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, DMEM_READ, 32'h102, 0); #2;
    checkOutput("misaligned rdata", dmemresp_rdata, 32'd0);
    tick(); idle(); #2;
    checkOutput("err after 0x102", 32'(err), 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 32'h3, 1, DMEM_READ, 32'h400, 0); #2;
    checkOutput("out-of-range rdata", dmemresp_rdata, 32'd0);
    checkOutput("illegal fetch data", imemresp_data, 32'd0);
    tick(); idle(); #2;
    checkOutput("err_addr held", err_addr, 32'h102);
    checkOutput("cnt_dread after errors", 32'(cnt_dread), 32'd4);
    checkOutput("cnt_ifetch after errors", 32'(cnt_ifetch), 32'd4);

    // Asynchronous reset with a write still pending in the buffer.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, DMEM_WRITE, 32'h108, 32'h12345678); tick();
    idle(); #1;
    rst = 1'b0; #1;
    checkOutput("async reset running", 32'(running), 32'd0);
    checkOutput("async reset cnt_dwrite", 32'(cnt_dwrite), 32'd0);
    checkOutput("async reset err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    applyStimulus(1, 32'h401, 32'h77, 0, 0, 0, 0, DMEM_READ, 0, 0); tick(); idle(); #2;
    checkOutput("load error err_addr", err_addr, 32'h401);
    applyStimulus(1, 32'h4, 32'h00000013, 0, 0, 0, 0, DMEM_READ, 0, 0); tick();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, DMEM_READ, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, DMEM_READ, 32'h108, 0); #2;
    checkOutput("0x108 keeps old value", dmemresp_rdata, 32'h00005555);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 32'h4, 1, DMEM_READ, 32'h100, 0); #2;
    checkOutput("0x100 survives reset", dmemresp_rdata, 32'hDEADBEEF);
    checkOutput("reloaded fetch 0x4", imemresp_data, 32'h00000013);
    tick();

    // Saturation: 20 more fetches push the 4-bit counter to all-ones.
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 0, DMEM_READ, 0, 0);
    repeat (20) tick();
    idle(); #2;
    checkOutput("sat cnt_ifetch", 32'(satIfetch), 32'hF);
    checkOutput("wide cnt_ifetch", 32'(cnt_ifetch), 32'd21);
    tick(); tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
